// File: rtl/prefetch_fetch_stage_if.sv
// Wishbone classic bus bundle used by the instruction fetch stage (read-only master).

interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_mosi, input dat_miso, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_mosi, output dat_miso, ack);
endinterface

// File: rtl/prefetch_fetch_stage.sv
// Instruction fetch stage: sequential Wishbone fetches into a prefetch queue that feeds decode;
// a jump flushes the queue and squashes any in-flight response.

package pipeline_status;
    typedef enum logic {BUBBLE = 1'b0, VALID = 1'b1} forwards_t;
    typedef enum logic [1:0] {READY = 2'd0, STALL = 2'd1, JUMP = 2'd2} backwards_t;
endpackage

package prefetch_fetch_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

module prefetch_fetch_stage
    import pipeline_status::*;
    import prefetch_fetch_stage_pkg::*;
#(
    parameter int unsigned PREFETCH_DEPTH = 4,
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    wishbone_interface.master     wb,
    output logic [31:0]           instruction_reg_out,
    output logic [31:0]           program_counter_reg_out,
    output forwards_t             status_forwards_out,
    input  backwards_t            status_backwards_in,
    input  logic [31:0]           jump_address_backwards_in
);

    localparam int unsigned PTR_W = $clog2(PREFETCH_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Bit 0 of the encoding is the bus-busy flag, so cyc/stb come straight from a flop.
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DISCARD = 2'b11} state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_pc_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       queue [PREFETCH_DEPTH];

    logic               jump_c;
    logic               ready_c;
    logic               push_c;
    logic               pop_c;
    logic               room_c;
    logic [31:0]        jump_target_c;
    fetch_entry_t       head_c;

    always_comb begin
        jump_c        = (status_backwards_in == JUMP);
        ready_c       = (status_backwards_in == READY);
        push_c        = (state == REQ) && wb.ack && !jump_c;
        pop_c         = ready_c && (count != '0);
        room_c        = (count + CNT_W'(push_c)) < CNT_W'(PREFETCH_DEPTH);
        jump_target_c = jump_address_backwards_in & 32'hFFFF_FFFC;
        head_c        = queue[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            IDLE: begin
                if (jump_c) fetch_pc_next = jump_target_c;
                if (jump_c || (count < CNT_W'(PREFETCH_DEPTH))) state_next = REQ;
            end
            REQ: begin
                if (wb.ack) begin
                    if (jump_c) begin
                        fetch_pc_next = jump_target_c;
                        state_next    = REQ;
                    end else begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        state_next    = room_c ? REQ : IDLE;
                    end
                end else if (jump_c) begin
                    fetch_pc_next = jump_target_c;
                    state_next    = DISCARD;
                end
            end
            DISCARD: begin
                if (jump_c) fetch_pc_next = jump_target_c;
                if (wb.ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb.cyc      = state[0];
        wb.stb      = state[0];
        wb.we       = 1'b0;
        wb.sel      = 4'hF;
        wb.adr      = fetch_pc;
        wb.dat_mosi = '0;
    end

    // Queue bookkeeping; a jump empties it regardless of any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (jump_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) queue[wr_ptr] <= '{pc: fetch_pc, instr: wb.dat_miso};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_reg_out     <= NOP_INSTR;
            program_counter_reg_out <= RESET_VECTOR;
            status_forwards_out     <= BUBBLE;
        end else begin
            case (status_backwards_in)
                READY: begin
                    if (pop_c) begin
                        instruction_reg_out     <= head_c.instr;
                        program_counter_reg_out <= head_c.pc;
                        status_forwards_out     <= VALID;
                    end else begin
                        instruction_reg_out <= NOP_INSTR;
                        status_forwards_out <= BUBBLE;
                    end
                end
                JUMP: begin
                    instruction_reg_out <= NOP_INSTR;
                    status_forwards_out <= BUBBLE;
                end
                default: ;
            endcase
        end
    end

endmodule
